// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes / InvSubBytes over a BYTES-byte state.
// LANES S-box lanes are time-multiplexed over N = BYTES/LANES chunks. Chunk k
// covers bytes k*LANES .. k*LANES+LANES-1 and chunks run in ascending order.
// Inverse mode reuses the forward S-box: InvS(y) = G(S(G(y))), where G is the
// inverse affine map. It takes two passes per chunk: S(G(byte)), then G(byte).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_inverse          0 = SubBytes, 1 = InvSubBytes, sampled on accept
//   in_data             state, byte b at [8b+7:8b]
//   out_valid/out_ready output handshake; the result is held until accepted
//   out_data            substituted state (always the state register)

// Forward AES S-box: multiplicative inverse in GF(2^8), then forward affine map.
module sub_bytes_iter_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // The inverse is x^254 built from a short addition chain; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module sub_bytes_iter #(
  parameter int BYTES = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inverse,
  input  logic [8*BYTES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data
);

  localparam int N  = BYTES / LANES;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (LANES < 1 || LANES > BYTES || (BYTES % LANES) != 0) begin : g_bad_params
    $error("sub_bytes_iter: LANES must divide BYTES and lie in 1..BYTES");
  end

  // Inverse affine map: rotr(v,2) ^ rotr(v,5) ^ rotr(v,7) ^ 8'h05.
  function automatic logic [7:0] aff_g(input logic [7:0] v);
    return {v[1:0], v[7:2]} ^ {v[4:0], v[7:5]} ^ {v[6:0], v[7]} ^ 8'h05;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [8*BYTES-1:0] data_q, data_d;
  logic [KW-1:0]      k_q, k_d;
  logic               phase_q, phase_d;
  logic               mode_q, mode_d;

  logic [7:0] lane_byte [LANES];
  logic [7:0] sbox_in   [LANES];
  logic [7:0] sbox_out  [LANES];
  logic [7:0] lane_wb   [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sub_bytes_iter_sbox u_sbox (
      .din  (sbox_in[j]),
      .dout (sbox_out[j])
    );
  end

  // Lane mux: inverse phase 0 feeds G(byte) to the S-box, inverse phase 1
  // writes back G(byte) directly, and forward mode writes S(byte).
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_byte[j] = data_q[(int'(k_q) * LANES + j) * 8 +: 8];
      sbox_in[j]   = (mode_q && !phase_q) ? aff_g(lane_byte[j]) : lane_byte[j];
      lane_wb[j]   = (mode_q && phase_q) ? aff_g(lane_byte[j]) : sbox_out[j];
    end
  end

  // Next-state logic. A chunk finishes every cycle in forward mode and on
  // phase 1 in inverse mode. k wraps to 0 as the FSM enters DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_inverse;
          k_d     = '0;
          phase_d = 1'b0;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        for (int j = 0; j < LANES; j++) begin
          data_d[(int'(k_q) * LANES + j) * 8 +: 8] = lane_wb[j];
        end
        if (mode_q) phase_d = ~phase_q;
        if (!mode_q || phase_q) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      k_q     <= '0;
      phase_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Testbench for sub_bytes_iter. The main instance (BYTES=16, LANES=4) covers
// forward/inverse results, latency, backpressure, back-to-back transfers and
// asynchronous reset. Four more instances (LANES 1, 2, 8, 16) run
// uniform-state round trips and check each instance's latency.
module tb_sub_bytes_iter;

  localparam logic [127:0] PLAIN   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FWD     = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] MIX_IN  = {{15{8'h63}}, 8'hed};
  localparam logic [127:0] MIX_OUT = 128'h53;
  localparam logic [127:0] ALL63   = {16{8'h63}};
  localparam logic [127:0] ALLED   = {16{8'hed}};
  localparam logic [127:0] ALL53   = {16{8'h53}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, in_inverse, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  logic         sw_in_valid, sw_in_inverse, sw_out_ready;
  logic [127:0] sw_in_data;
  logic         sw_in_ready  [4];
  logic         sw_out_valid [4];
  logic [127:0] sw_out_data  [4];

  int errors = 0;
  int checks = 0;
  int lat;

  sub_bytes_iter #(.BYTES(16), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inverse(in_inverse), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  sub_bytes_iter #(.BYTES(16), .LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]),
    .in_inverse(sw_in_inverse), .in_data(sw_in_data), .out_valid(sw_out_valid[0]),
    .out_ready(sw_out_ready), .out_data(sw_out_data[0])
  );

  sub_bytes_iter #(.BYTES(16), .LANES(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]),
    .in_inverse(sw_in_inverse), .in_data(sw_in_data), .out_valid(sw_out_valid[1]),
    .out_ready(sw_out_ready), .out_data(sw_out_data[1])
  );

  sub_bytes_iter #(.BYTES(16), .LANES(8)) dut_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]),
    .in_inverse(sw_in_inverse), .in_data(sw_in_data), .out_valid(sw_out_valid[2]),
    .out_ready(sw_out_ready), .out_data(sw_out_data[2])
  );

  sub_bytes_iter #(.BYTES(16), .LANES(16)) dut_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[3]),
    .in_inverse(sw_in_inverse), .in_data(sw_in_data), .out_valid(sw_out_valid[3]),
    .out_ready(sw_out_ready), .out_data(sw_out_data[3])
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for out_valid on the main instance, counting edges; lat enters
  // holding the edges already counted.
  task automatic waitValid(inout int lat);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", {127'd0, out_valid}, 128'd1);
  endtask

  // Offers one transaction while in_ready is high. lat counts edges from the
  // accept edge (inclusive) to the edge that raises out_valid.
  task automatic applyStimulus(input logic [127:0] data, input logic inv, output int lat);
    in_data    = data;
    in_inverse = inv;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    waitValid(lat);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Drives the same transaction into all four sweep instances and checks each
  // one's latency and result.
  task automatic runSweep(input logic [127:0] data, input logic inv, input logic [127:0] exp);
    int lanes [4] = '{1, 2, 8, 16};
    int lat_sw [4];
    logic [127:0] got [4];
    int cnt;
    bit pending;
    for (int i = 0; i < 4; i++) lat_sw[i] = 0;
    sw_in_data    = data;
    sw_in_inverse = inv;
    sw_in_valid   = 1'b1;
    cnt = 0;
    pending = 1'b1;
    while (pending && cnt < 40) begin
      @(posedge clk); #1;
      sw_in_valid = 1'b0;
      cnt++;
      pending = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (sw_out_valid[i] && lat_sw[i] == 0) begin
          lat_sw[i] = cnt;
          got[i]    = sw_out_data[i];
        end
        if (lat_sw[i] == 0) pending = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 16 / lanes[i];
      checkOutput($sformatf("sw_L%0d_inv%0d_lat", lanes[i], inv), 128'(lat_sw[i]),
                  128'(inv ? 2 * n + 1 : n + 1));
      if (lat_sw[i] != 0)
        checkOutput($sformatf("sw_L%0d_inv%0d_data", lanes[i], inv), got[i], exp);
    end
    sw_out_ready = 1'b1;
    @(posedge clk); #1;
    sw_out_ready = 1'b0;
    checkOutput("sw_in_ready_after", {124'd0, sw_in_ready[3], sw_in_ready[2], sw_in_ready[1], sw_in_ready[0]},
                128'hf);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_inverse = 1'b0; in_data = '0; out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_in_inverse = 1'b0; sw_in_data = '0; sw_out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_out_data", out_data, 128'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] forward 00..0f with backpressure");
    applyStimulus(PLAIN, 1'b0, lat);
    checkOutput("fwd_latency", 128'(lat), 128'd5);
    checkOutput("fwd_data", out_data, FWD);
    for (int i = 0; i < 10; i++) begin
      in_valid   = (i % 3 == 0);
      in_data    = ~PLAIN;
      in_inverse = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", {127'd0, out_valid}, 128'd1);
      checkOutput("bp_out_data", out_data, FWD);
      checkOutput("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    retire();
    checkOutput("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("bp_release_in_ready", {127'd0, in_ready}, 128'd1);

    $display("[TB] inverse round trip");
    applyStimulus(FWD, 1'b1, lat);
    checkOutput("inv_latency", 128'(lat), 128'd9);
    checkOutput("inv_data", out_data, PLAIN);
    retire();
    applyStimulus(MIX_IN, 1'b1, lat);
    checkOutput("inv_ed_63", out_data, MIX_OUT);
    retire();

    $display("[TB] back-to-back with in_valid held");
    out_ready  = 1'b1;
    in_data    = PLAIN;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_data    = FWD;
    in_inverse = 1'b1;
    lat = 1;
    waitValid(lat);
    checkOutput("b2b_fwd_latency", 128'(lat), 128'd5);
    checkOutput("b2b_fwd_data", out_data, FWD);
    @(posedge clk); #1;
    checkOutput("b2b_idle_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    checkOutput("b2b_second_accept", {127'd0, in_ready}, 128'd0);
    in_valid = 1'b0; in_data = '0; in_inverse = 1'b0;
    lat = 1;
    waitValid(lat);
    checkOutput("b2b_inv_latency", 128'(lat), 128'd9);
    checkOutput("b2b_inv_data", out_data, PLAIN);
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] asynchronous reset mid-transaction");
    in_data = PLAIN; in_inverse = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("midrst_out_data", out_data, 128'd0);
    checkOutput("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(ALL53, 1'b0, lat);
    checkOutput("postrst_latency", 128'(lat), 128'd5);
    checkOutput("postrst_data", out_data, ALLED);
    retire();

    $display("[TB] lane sweep");
    runSweep(128'd0, 1'b0, ALL63);
    runSweep(ALL63, 1'b1, 128'd0);
    runSweep(ALL53, 1'b0, ALLED);
    runSweep(ALLED, 1'b1, ALL53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
